// File: rtl/iir_out_gain_if.sv
// ============================================================================
// iir_out_gain_if: AXI-Stream and Wishbone-style config bus interfaces. Rev 1.0
// ============================================================================
`default_nettype none

interface axis_if #(
  parameter int DW = 24
);
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

interface cfg_bus_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          cyc_i;
  logic          stb_i;
  logic          we_i;
  logic          ack_o;
  logic          stall_o;
  logic [AW-1:0] addr_i;
  logic [DW-1:0] data_i;
  logic [DW-1:0] data_o;

  modport master (output cyc_i, output stb_i, output we_i, output addr_i, output data_i,
                  input ack_o, input stall_o, input data_o);
  modport slave  (input cyc_i, input stb_i, input we_i, input addr_i, input data_i,
                  output ack_o, output stall_o, output data_o);
endinterface

`default_nettype wire

// File: rtl/iir_out_gain.sv
// ============================================================================
// iir_out_gain: IIR output gain, round-half-up and saturate; optional clip/peak
// statistics when IIR_OUT_GAIN_STATS_EN is defined. Rev 1.0
// ============================================================================
`default_nettype none

module iir_out_gain #(
  parameter int DW    = 24,
  parameter int CFGAW = 32,
  parameter int CFGDW = 32,
  parameter int GAINW = 18,
  parameter int GAINQ = 16
) (
  input  logic       clk,
  input  logic       rst,
  axis_if.slave      s_axis,
  axis_if.master     m_axis,
  cfg_bus_if.slave   cfg
);

  localparam int PW = DW + GAINW;
  localparam logic signed [GAINW-1:0] GAIN_ONE = GAINW'(1 << GAINQ);
  localparam logic signed [PW-1:0]    RND      = {{(PW-GAINQ){1'b0}}, 1'b1, {(GAINQ-1){1'b0}}};
  localparam logic [DW-1:0]           SAT_MAX  = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0]           SAT_MIN  = {1'b1, {(DW-1){1'b0}}};

  logic                    ce;
  logic signed [GAINW-1:0] gain;
  logic                    s1_valid;
  logic signed [PW-1:0]    s1_prod;
  logic signed [PW-1:0]    data_ext;
  logic signed [PW-1:0]    gain_ext;
  logic signed [PW-1:0]    rounded;
  logic signed [PW-1:0]    shifted;
  logic                    ovf;
  logic [DW-1:0]           sat;

  logic                    acc;
  logic                    wr;
  logic                    sel_gain;
  logic                    sel_clip;
  logic                    sel_peak;
  logic [CFGDW-1:0]        rd_data;
  logic                    unused_bits;

  // Stall of the output freezes the whole pipe, bubbles included.
  assign ce            = !m_axis.tvalid || m_axis.tready;
  assign s_axis.tready = ce;

  assign data_ext = PW'($signed(s_axis.tdata));
  assign gain_ext = PW'(gain);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_prod  <= '0;
    end else if (ce) begin
      s1_valid <= s_axis.tvalid;
      if (s_axis.tvalid)
        s1_prod <= data_ext * gain_ext;
    end
  end

  always_comb begin
    rounded = s1_prod + RND;
    shifted = rounded >>> GAINQ;
    // Result fits only if every bit above the output sign bit copies it.
    ovf     = !((&shifted[PW-1:DW-1]) || !(|shifted[PW-1:DW-1]));
    sat     = ovf ? (shifted[PW-1] ? SAT_MIN : SAT_MAX) : shifted[DW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axis.tvalid <= 1'b0;
      m_axis.tdata  <= '0;
    end else if (ce) begin
      m_axis.tvalid <= s1_valid;
      if (s1_valid)
        m_axis.tdata <= sat;
    end
  end

  assign acc      = cfg.cyc_i && cfg.stb_i;
  assign wr       = acc && cfg.we_i;
  assign sel_gain = (cfg.addr_i == CFGAW'(0));
  assign sel_clip = (cfg.addr_i == CFGAW'(1));
  assign sel_peak = (cfg.addr_i == CFGAW'(2));

  assign cfg.stall_o = 1'b0;
  assign unused_bits = ^cfg.data_i[CFGDW-1:GAINW];

`ifdef IIR_OUT_GAIN_STATS_EN
  logic             deliver;
  logic [CFGDW-1:0] clip_count;
  logic [DW-1:0]    peak;
  logic [DW-1:0]    abs_out;

  assign deliver = ce && s1_valid;
  // Two's-complement negate in DW bits maps the most negative value to 2^(DW-1).
  assign abs_out = sat[DW-1] ? (~sat + 1'b1) : sat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clip_count <= '0;
      peak       <= '0;
    end else begin
      if (wr && sel_clip)
        clip_count <= '0;
      else if (deliver && ovf && (clip_count != {CFGDW{1'b1}}))
        clip_count <= clip_count + 1'b1;

      if (wr && sel_peak)
        peak <= '0;
      else if (deliver && (abs_out > peak))
        peak <= abs_out;
    end
  end
`endif

  always_comb begin
    rd_data = '0;
    if (sel_gain)
      rd_data = {{(CFGDW-GAINW){gain[GAINW-1]}}, gain};
`ifdef IIR_OUT_GAIN_STATS_EN
    else if (sel_clip)
      rd_data = clip_count;
    else if (sel_peak)
      rd_data = CFGDW'(peak);
`else
    else if (sel_clip || sel_peak)
      rd_data = '0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg.ack_o  <= 1'b0;
      cfg.data_o <= '0;
      gain       <= GAIN_ONE;
    end else begin
      cfg.ack_o <= acc;
      if (acc)
        cfg.data_o <= rd_data;
      if (wr && sel_gain)
        gain <= cfg.data_i[GAINW-1:0];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_iir_out_gain.sv
// ============================================================================
// tb_iir_out_gain: directed vectors with a queue scoreboard and stream monitor.
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_iir_out_gain;
  localparam int DW    = 24;
  localparam int CFGAW = 32;
  localparam int CFGDW = 32;
  localparam int GAINW = 18;
  localparam int GAINQ = 16;

`ifdef IIR_OUT_GAIN_STATS_EN
  localparam logic [31:0] EXP_CLIP = 32'd2;
  localparam logic [31:0] EXP_PEAK = 32'h0080_0000;
`else
  localparam logic [31:0] EXP_CLIP = 32'd0;
  localparam logic [31:0] EXP_PEAK = 32'd0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axis_if    #(.DW(DW))                  s_axis ();
  axis_if    #(.DW(DW))                  m_axis ();
  cfg_bus_if #(.AW(CFGAW), .DW(CFGDW))   cfg ();

  iir_out_gain #(
    .DW(DW), .CFGAW(CFGAW), .CFGDW(CFGDW), .GAINW(GAINW), .GAINQ(GAINQ)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .s_axis (s_axis),
    .m_axis (m_axis),
    .cfg    (cfg)
  );

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_q[$];
  bit            rnd_ready = 1'b0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
  endtask

  // Monitor: pops the scoreboard on every output handshake and checks stall stability.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 32'(m_axis.tvalid), 32'd1);
        chk("stall_data", 32'(m_axis.tdata), 32'(prev_data));
      end
      if (m_axis.tvalid && m_axis.tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got 0x%06h expected none", m_axis.tdata);
        end else begin
          chk("out_data", 32'(m_axis.tdata), 32'(exp_q.pop_front()));
        end
      end
      prev_stall = m_axis.tvalid && !m_axis.tready;
      prev_data  = m_axis.tdata;
    end
  end

  task automatic bus(input logic we, input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] rd);
    cfg.cyc_i  = 1'b1;
    cfg.stb_i  = 1'b1;
    cfg.we_i   = we;
    cfg.addr_i = a;
    cfg.data_i = wd;
    @(posedge clk); #1;
    cfg.cyc_i = 1'b0;
    cfg.stb_i = 1'b0;
    cfg.we_i  = 1'b0;
    chk("ack_pulse", 32'(cfg.ack_o), 32'd1);
    rd = cfg.data_o;
    @(posedge clk); #1;
    chk("ack_drop", 32'(cfg.ack_o), 32'd0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    bus(1'b1, a, d, r);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    bus(1'b0, a, 32'd0, r);
    chk(name, r, exp);
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the sample.
  task automatic send(input int x, input int e);
    bit done = 1'b0;
    s_axis.tdata  = DW'(x);
    s_axis.tvalid = 1'b1;
    if (rnd_ready) m_axis.tready = 1'($urandom_range(0, 1));
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (s_axis.tready) begin
        exp_q.push_back(DW'(e));
        done = 1'b1;
      end
      @(posedge clk); #1;
      if (!done && rnd_ready) m_axis.tready = 1'($urandom_range(0, 1));
    end
    s_axis.tvalid = 1'b0;
    if (!done) timeout_fail("send_accept");
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) begin
      @(posedge clk); #1;
    end
    if (exp_q.size() != 0) timeout_fail("drain");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    s_axis.tdata  = '0;
    s_axis.tvalid = 1'b0;
    m_axis.tready = 1'b1;
    cfg.cyc_i     = 1'b0;
    cfg.stb_i     = 1'b0;
    cfg.we_i      = 1'b0;
    cfg.addr_i    = '0;
    cfg.data_i    = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_s_tready", 32'(s_axis.tready), 32'd1);
    chk("rst_m_tvalid", 32'(m_axis.tvalid), 32'd0);
    chk("rst_m_tdata", 32'(m_axis.tdata), 32'd0);
    chk("rst_ack", 32'(cfg.ack_o), 32'd0);
    chk("rst_data_o", cfg.data_o, 32'd0);
    chk("rst_stall", 32'(cfg.stall_o), 32'd0);

    // Unity gain, pipeline latency.
    rd_chk("gain_reset", 32'd0, 32'h0001_0000);
    send(1000, 1000);
    @(negedge clk);
    chk("lat_cycle1_valid", 32'(m_axis.tvalid), 32'd0);
    @(negedge clk);
    chk("lat_cycle2_valid", 32'(m_axis.tvalid), 32'd1);
    chk("lat_cycle2_data", 32'(m_axis.tdata), 32'd1000);
    @(posedge clk); #1;
    send(-1000, -1000);
    send(0, 0);
    drain();

    // Half gain: round-half-up.
    wr(32'd0, 32'h0000_8000);
    rd_chk("gain_half", 32'd0, 32'h0000_8000);
    send(3, 2);
    send(-3, -1);
    send(5, 3);
    drain();

    // Gain 1.5 with saturation and stats.
    wr(32'd0, 32'h0001_8000);
    send(32'h60_0000, 32'h7F_FFFF);
    send(-32'h60_0000, -32'h80_0000);
    send(32'h10_0000, 32'h18_0000);
    drain();
    rd_chk("clip_count", 32'd1, EXP_CLIP);
    rd_chk("peak", 32'd2, EXP_PEAK);
    wr(32'd1, 32'd0);
    rd_chk("clip_cleared", 32'd1, 32'd0);
    wr(32'd2, 32'd0);
    rd_chk("peak_cleared", 32'd2, 32'd0);
    rd_chk("unmapped", 32'd7, 32'd0);

    // Continuous stream with random backpressure, gain still 1.5.
    rnd_ready = 1'b1;
    for (int i = 0; i < 100; i++) send(i, (3 * i + 1) / 2);
    rnd_ready = 1'b0;
    m_axis.tready = 1'b1;
    drain();

    // Reset with two samples held in the pipe.
    m_axis.tready = 1'b0;
    send(11, 17);
    send(12, 18);
    rst = 1'b1;
    #1;
    chk("midrst_tvalid", 32'(m_axis.tvalid), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    m_axis.tready = 1'b1;
    rd_chk("midrst_gain", 32'd0, 32'h0001_0000);
    send(77, 77);
    drain();

    // Gain write truncated to 18 bits: -2.0.
    wr(32'd0, 32'h0002_0000);
    rd_chk("gain_trunc", 32'd0, 32'hFFFE_0000);
    send(100, -200);
    drain();

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
